// File: rtl/writeback_stage_pkg.sv
// Shared definitions for the writeback stage and its helpers.
// Holds the datapath widths, load funct3 codes and the writeback FSM state type.
package instructions_pkg;

  localparam int XLEN         = 32;
  localparam int MSB_REG_FILE = 5;

  typedef enum logic {
    IDLE,
    WAIT_LOAD
  } wb_state_t;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  // x0 is hardwired to zero, so a write to it is never a real write.
  function automatic logic rf_write_en(input logic wb_en, input logic [MSB_REG_FILE-1:0] rd);
    return wb_en && (rd != '0);
  endfunction

endpackage

// File: rtl/writeback_stage_if.sv
// Ps5 -> Ps6 handshake plus the data-memory load response.
// The master (memory stage) drives the instruction and response; the slave (writeback) drives wb_ready.
interface writeback_stage_if;
  import instructions_pkg::*;

  logic                    mem_valid;
  logic                    wb_ready;
  logic [MSB_REG_FILE-1:0] mem_rd;
  logic                    mem_wb_en;
  logic                    mem_is_load;
  logic [2:0]              mem_funct3;
  logic [1:0]              mem_addr_lsb;
  logic [XLEN-1:0]         mem_result;
  logic                    dmem_rvalid;
  logic [XLEN-1:0]         dmem_rdata;

  modport master (
    output mem_valid, mem_rd, mem_wb_en, mem_is_load, mem_funct3,
           mem_addr_lsb, mem_result, dmem_rvalid, dmem_rdata,
    input  wb_ready
  );

  modport slave (
    input  mem_valid, mem_rd, mem_wb_en, mem_is_load, mem_funct3,
           mem_addr_lsb, mem_result, dmem_rvalid, dmem_rdata,
    output wb_ready
  );

endinterface

// File: rtl/writeback_stage_load_align.sv
// Combinational load alignment: picks the byte/half/word at the given offset and extends it.
// Also classifies funct3/offset combinations that cannot be executed.
module load_align
  import instructions_pkg::*;
(
  input  logic [2:0]      funct3,
  input  logic [1:0]      lsb,
  input  logic [XLEN-1:0] rdata,
  output logic [XLEN-1:0] data,
  output logic            illegal,
  output logic            misaligned
);

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  assign byte_v = rdata[{lsb, 3'b000} +: 8];
  assign half_v = lsb[1] ? rdata[31:16] : rdata[15:0];

  always_comb begin
    data       = '0;
    illegal    = 1'b0;
    misaligned = 1'b0;
    case (funct3)
      LD_B:  data = {{(XLEN-8){byte_v[7]}}, byte_v};
      LD_BU: data = {{(XLEN-8){1'b0}}, byte_v};
      LD_H: begin
        data       = {{(XLEN-16){half_v[15]}}, half_v};
        misaligned = lsb[0];
      end
      LD_HU: begin
        data       = {{(XLEN-16){1'b0}}, half_v};
        misaligned = lsb[0];
      end
      LD_W: begin
        data       = rdata;
        misaligned = (lsb != 2'b00);
      end
      default: illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/writeback_stage.sv
// Ps6 writeback: retires ALU results in one cycle and loads after the data-memory response.
// state     | meaning
// IDLE      | ready; non-loads retire here, loads are checked and launched
// WAIT_LOAD | load in flight, waiting for dmem_rvalid or timeout
module writeback_stage
  import instructions_pkg::*;
#(
  parameter int LOAD_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  writeback_stage_if.slave        wb,
  output logic [MSB_REG_FILE-1:0] rd_Ps6,
  output logic                    CtrlWriteEn,
  output logic [XLEN-1:0]         DataRd,
  output logic                    err_misaligned,
  output logic                    err_illegal_load,
  output logic                    err_timeout,
  output logic                    err_spurious,
  output logic [CNT_W-1:0]        retire_cnt
);

  localparam int TMO_W = $clog2(LOAD_TIMEOUT);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(LOAD_TIMEOUT - 1);

  wb_state_t               state;
  logic [TMO_W-1:0]        tmo_cnt;
  logic [MSB_REG_FILE-1:0] ld_rd;
  logic                    ld_wb_en;
  logic [2:0]              ld_funct3;
  logic [1:0]              ld_lsb;

  logic [2:0]      al_funct3;
  logic [1:0]      al_lsb;
  logic [XLEN-1:0] al_data;
  logic            al_illegal;
  logic            al_misaligned;
  logic            nl_we;
  logic            ld_we;

  assign wb.wb_ready = (state == IDLE);

  // One aligner serves both the accept-time checks and the response extraction.
  assign al_funct3 = (state == IDLE) ? wb.mem_funct3   : ld_funct3;
  assign al_lsb    = (state == IDLE) ? wb.mem_addr_lsb : ld_lsb;

  load_align u_load_align (
    .funct3     (al_funct3),
    .lsb        (al_lsb),
    .rdata      (wb.dmem_rdata),
    .data       (al_data),
    .illegal    (al_illegal),
    .misaligned (al_misaligned)
  );

  assign nl_we = rf_write_en(wb.mem_wb_en, wb.mem_rd);
  assign ld_we = rf_write_en(ld_wb_en, ld_rd);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      tmo_cnt          <= '0;
      ld_rd            <= '0;
      ld_wb_en         <= 1'b0;
      ld_funct3        <= '0;
      ld_lsb           <= '0;
      rd_Ps6           <= '0;
      CtrlWriteEn      <= 1'b0;
      DataRd           <= '0;
      err_misaligned   <= 1'b0;
      err_illegal_load <= 1'b0;
      err_timeout      <= 1'b0;
      err_spurious     <= 1'b0;
      retire_cnt       <= '0;
    end else begin
      CtrlWriteEn <= 1'b0;
      case (state)
        IDLE: begin
          if (wb.dmem_rvalid) err_spurious <= 1'b1;
          if (wb.mem_valid) begin
            if (!wb.mem_is_load) begin
              rd_Ps6      <= wb.mem_rd;
              DataRd      <= wb.mem_result;
              CtrlWriteEn <= nl_we;
              if (nl_we) retire_cnt <= retire_cnt + CNT_W'(1);
            end else if (al_illegal) begin
              err_illegal_load <= 1'b1;
            end else if (al_misaligned) begin
              err_misaligned <= 1'b1;
            end else begin
              ld_rd     <= wb.mem_rd;
              ld_wb_en  <= wb.mem_wb_en;
              ld_funct3 <= wb.mem_funct3;
              ld_lsb    <= wb.mem_addr_lsb;
              tmo_cnt   <= '0;
              state     <= WAIT_LOAD;
            end
          end
        end
        WAIT_LOAD: begin
          // Response beats the timeout when both land on the same cycle.
          if (wb.dmem_rvalid) begin
            rd_Ps6      <= ld_rd;
            DataRd      <= al_data;
            CtrlWriteEn <= ld_we;
            if (ld_we) retire_cnt <= retire_cnt + CNT_W'(1);
            state       <= IDLE;
          end else if (tmo_cnt == TMO_LAST) begin
            err_timeout <= 1'b1;
            state       <= IDLE;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_stage.sv
// Bench for writeback_stage: directed scenarios with literal expectations, then random traffic
// compared every cycle against a transaction-level model of the stage.
module tb_writeback_stage;

  localparam int LOAD_TIMEOUT = 16;
  localparam int CNT_W        = 32;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  rd_Ps6;
  logic        CtrlWriteEn;
  logic [31:0] DataRd;
  logic        err_misaligned, err_illegal_load, err_timeout, err_spurious;
  logic [31:0] retire_cnt;

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  writeback_stage_if wb ();

  writeback_stage #(.LOAD_TIMEOUT(LOAD_TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .wb               (wb),
    .rd_Ps6           (rd_Ps6),
    .CtrlWriteEn      (CtrlWriteEn),
    .DataRd           (DataRd),
    .err_misaligned   (err_misaligned),
    .err_illegal_load (err_illegal_load),
    .err_timeout      (err_timeout),
    .err_spurious     (err_spurious),
    .retire_cnt       (retire_cnt)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  typedef struct packed {
    bit          busy;
    logic [31:0] waited;
    logic [4:0]  p_rd;
    bit          p_wb_en;
    logic [2:0]  p_f3;
    logic [1:0]  p_lsb;
    bit          we;
    logic [4:0]  rd;
    logic [31:0] data;
    bit          e_mis;
    bit          e_ill;
    bit          e_to;
    bit          e_sp;
    logic [31:0] cnt;
  } model_t;

  model_t mdl = '0;

  function automatic bit f3_legal(input logic [2:0] f3);
    return f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  endfunction

  function automatic logic [31:0] access_bytes(input logic [2:0] f3);
    return (f3[1:0] == 2'd0) ? 32'd1 : (f3[1:0] == 2'd1) ? 32'd2 : 32'd4;
  endfunction

  function automatic logic [31:0] extract(input logic [2:0] f3, input logic [1:0] lsb, input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (32'(lsb) * 32'd8)) & 32'hFF;
    h = (w >> ((32'(lsb) / 32'd2) * 32'd16)) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 32'd128)   ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic model_t retire(input model_t m, input logic [4:0] rd, input bit wb_en, input logic [31:0] d);
    model_t n = m;
    n.rd   = rd;
    n.data = d;
    n.we   = wb_en && (rd != 5'd0);
    if (n.we) n.cnt = m.cnt + 32'd1;
    return n;
  endfunction

  function automatic model_t model_next(input model_t m);
    model_t n = m;
    n.we = 1'b0;
    if (!m.busy) begin
      if (wb.dmem_rvalid) n.e_sp = 1'b1;
      if (wb.mem_valid) begin
        if (!wb.mem_is_load)
          n = retire(n, wb.mem_rd, wb.mem_wb_en, wb.mem_result);
        else if (!f3_legal(wb.mem_funct3))
          n.e_ill = 1'b1;
        else if ((32'(wb.mem_addr_lsb) % access_bytes(wb.mem_funct3)) != 32'd0)
          n.e_mis = 1'b1;
        else begin
          n.busy    = 1'b1;
          n.waited  = 32'd0;
          n.p_rd    = wb.mem_rd;
          n.p_wb_en = wb.mem_wb_en;
          n.p_f3    = wb.mem_funct3;
          n.p_lsb   = wb.mem_addr_lsb;
        end
      end
    end else if (wb.dmem_rvalid) begin
      n      = retire(n, m.p_rd, m.p_wb_en, extract(m.p_f3, m.p_lsb, wb.dmem_rdata));
      n.busy = 1'b0;
    end else begin
      // The LOAD_TIMEOUT-th silent cycle in flight aborts the load.
      n.waited = m.waited + 32'd1;
      if (n.waited == 32'(LOAD_TIMEOUT)) begin
        n.e_to = 1'b1;
        n.busy = 1'b0;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) mdl <= '0;
    else     mdl <= model_next(mdl);
  end

  // ---------------- checking ----------------
  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endfunction

  always @(negedge clk) begin
    if (cmp_en) begin
      check("m_wb_ready",    32'(wb.wb_ready),   32'(!mdl.busy));
      check("m_CtrlWriteEn", 32'(CtrlWriteEn),   32'(mdl.we));
      check("m_rd_Ps6",      32'(rd_Ps6),        32'(mdl.rd));
      check("m_DataRd",      DataRd,             mdl.data);
      check("m_errs",        32'({err_misaligned, err_illegal_load, err_timeout, err_spurious}),
                             32'({mdl.e_mis, mdl.e_ill, mdl.e_to, mdl.e_sp}));
      check("m_retire_cnt",  retire_cnt,         mdl.cnt);
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic put_idle();
    wb.mem_valid    = 1'b0;
    wb.mem_is_load  = 1'b0;
    wb.mem_wb_en    = 1'b0;
    wb.mem_rd       = 5'd0;
    wb.mem_funct3   = 3'd0;
    wb.mem_addr_lsb = 2'd0;
    wb.mem_result   = 32'd0;
    wb.dmem_rvalid  = 1'b0;
    wb.dmem_rdata   = 32'd0;
  endtask

  task automatic put_nonload(input logic [4:0] rd, input logic wb_en, input logic [31:0] res);
    wb.mem_valid   = 1'b1;
    wb.mem_is_load = 1'b0;
    wb.mem_rd      = rd;
    wb.mem_wb_en   = wb_en;
    wb.mem_result  = res;
  endtask

  task automatic put_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [4:0] rd);
    wb.mem_valid    = 1'b1;
    wb.mem_is_load  = 1'b1;
    wb.mem_rd       = rd;
    wb.mem_wb_en    = 1'b1;
    wb.mem_funct3   = f3;
    wb.mem_addr_lsb = lsb;
    wb.mem_result   = 32'h5A5A_5A5A;
  endtask

  task automatic run_load(input logic [2:0] f3, input logic [1:0] lsb, input logic [4:0] rd,
                          input logic [31:0] rdata);
    put_load(f3, lsb, rd);
    tick();
    put_idle();
    check("ld_busy0", 32'(wb.wb_ready), 32'd0);
    tick();
    check("ld_busy1", 32'(wb.wb_ready), 32'd0);
    wb.dmem_rvalid = 1'b1;
    wb.dmem_rdata  = rdata;
    tick();
    put_idle();
  endtask

  logic [2:0] legal_f3 [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

  initial begin
    bit rdy_prev, busy_prev, silent, xfer;
    put_idle();
    #1 rst = 1'b1;
    cmp_en = 1'b1;

    // model pins
    check("pin_lb",  extract(3'd0, 2'd3, 32'h80FF_0011), 32'hFFFF_FF80);
    check("pin_lbu", extract(3'd4, 2'd3, 32'h80FF_0011), 32'h0000_0080);
    check("pin_lhu", extract(3'd5, 2'd2, 32'h8001_7FFF), 32'h0000_8001);
    check("pin_lh",  extract(3'd1, 2'd0, 32'h8001_8FFF), 32'hFFFF_8FFF);

    repeat (2) @(negedge clk);
    check("rst_we",   32'(CtrlWriteEn), 32'd0);
    check("rst_cnt",  retire_cnt,       32'd0);
    check("rst_rdy",  32'(wb.wb_ready), 32'd1);
    rst = 1'b0;

    put_nonload(5'd5, 1'b1, 32'hDEAD_BEEF);
    tick();
    check("nl_we",   32'(CtrlWriteEn), 32'd1);
    check("nl_rd",   32'(rd_Ps6),      32'd5);
    check("nl_data", DataRd,           32'hDEAD_BEEF);
    check("nl_cnt",  retire_cnt,       32'd1);
    put_nonload(5'd6, 1'b1, 32'h0000_0066);
    tick();
    check("b2b_we",  32'(CtrlWriteEn), 32'd1);
    check("b2b_rd",  32'(rd_Ps6),      32'd6);
    check("b2b_cnt", retire_cnt,       32'd2);
    put_nonload(5'd0, 1'b1, 32'h0000_1234);
    tick();
    put_idle();
    check("x0_we",   32'(CtrlWriteEn), 32'd0);
    check("x0_data", DataRd,           32'h0000_1234);
    check("x0_cnt",  retire_cnt,       32'd2);
    tick();
    check("idle_we", 32'(CtrlWriteEn), 32'd0);

    run_load(3'd0, 2'd3, 5'd7, 32'h80FF_0011);
    check("lb_we",   32'(CtrlWriteEn), 32'd1);
    check("lb_data", DataRd,           32'hFFFF_FF80);
    check("lb_rdy",  32'(wb.wb_ready), 32'd1);
    run_load(3'd4, 2'd3, 5'd7, 32'h80FF_0011);
    check("lbu_data", DataRd, 32'h0000_0080);
    run_load(3'd5, 2'd2, 5'd8, 32'h8001_7FFF);
    check("lhu_data", DataRd,     32'h0000_8001);
    check("lhu_cnt",  retire_cnt, 32'd5);

    put_load(3'd1, 2'd1, 5'd9);
    tick();
    put_idle();
    check("mis_flag", 32'(err_misaligned), 32'd1);
    check("mis_we",   32'(CtrlWriteEn),    32'd0);
    check("mis_rdy",  32'(wb.wb_ready),    32'd1);
    put_load(3'd3, 2'd0, 5'd9);
    tick();
    put_idle();
    check("ill_flag", 32'(err_illegal_load), 32'd1);

    put_load(3'd2, 2'd0, 5'd11);
    tick();
    put_idle();
    repeat (LOAD_TIMEOUT - 1) tick();
    check("to_early", 32'(err_timeout), 32'd0);
    check("to_busy",  32'(wb.wb_ready), 32'd0);
    tick();
    check("to_flag",  32'(err_timeout), 32'd1);
    check("to_rdy",   32'(wb.wb_ready), 32'd1);
    check("to_we",    32'(CtrlWriteEn), 32'd0);
    wb.dmem_rvalid = 1'b1;
    tick();
    put_idle();
    check("sp_flag",  32'(err_spurious), 32'd1);
    check("sp_cnt",   retire_cnt,        32'd5);

    put_load(3'd2, 2'd0, 5'd10);
    tick();
    put_idle();
    tick();
    #2 rst = 1'b1;
    #1;
    check("arst_rdy",  32'(wb.wb_ready), 32'd1);
    check("arst_data", DataRd,           32'd0);
    check("arst_cnt",  retire_cnt,       32'd0);
    check("arst_errs", 32'({err_misaligned, err_illegal_load, err_timeout, err_spurious}), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    put_nonload(5'd9, 1'b1, 32'h0000_CAFE);
    tick();
    put_idle();
    check("post_we",   32'(CtrlWriteEn), 32'd1);
    check("post_rd",   32'(rd_Ps6),      32'd9);
    check("post_data", DataRd,           32'h0000_CAFE);
    check("post_cnt",  retire_cnt,       32'd1);

    // random traffic; an offered instruction is held until it is taken
    rdy_prev  = wb.wb_ready;
    busy_prev = 1'b0;
    silent    = 1'b0;
    for (int cyc = 0; cyc < 4000; cyc++) begin
      xfer = wb.mem_valid && rdy_prev;
      if (!(wb.mem_valid && !xfer)) begin
        wb.mem_valid    = ($urandom_range(0, 9) < 7);
        wb.mem_is_load  = ($urandom_range(0, 9) < 4);
        wb.mem_funct3   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(0, 7))
                                                      : legal_f3[$urandom_range(0, 4)];
        wb.mem_addr_lsb = 2'($urandom_range(0, 3));
        wb.mem_rd       = 5'($urandom_range(0, 31));
        wb.mem_wb_en    = ($urandom_range(0, 5) != 0);
        wb.mem_result   = $urandom();
      end
      if (!wb.wb_ready) begin
        if (!busy_prev) silent = ($urandom_range(0, 9) == 0);
        wb.dmem_rvalid = !silent && ($urandom_range(0, 2) == 0);
      end else begin
        wb.dmem_rvalid = ($urandom_range(0, 199) == 0);
      end
      wb.dmem_rdata = $urandom();
      busy_prev = !wb.wb_ready;
      rdy_prev  = wb.wb_ready;
      tick();
    end
    put_idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
